// File: rtl/xgemac_rx_pkt_source.sv
// xgemac_rx_pkt_source
//
// MAC-side source of the packet receive interface. Frame words arriving from
// the MAC RX datapath are stored in a circular buffer. They are presented on
// pkt_rx_* only once a complete frame, meaning its eop word, has been stored.
// This way a consumer never starts reading a frame that could stall halfway.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   wr_val           write-side word valid (no backpressure; see wr_full)
//   wr_data          write word
//   wr_sop/wr_eop    first / last word of frame
//   wr_mod           valid bytes on eop word (0 = all bytes)
//   wr_err           frame error, carried on eop word
//   wr_full          buffer holds DEPTH words; writes while high are dropped
//   drop_cnt         saturating count of dropped writes
//   pkt_rx_ren       read enable from consumer
//   pkt_rx_avail     at least one complete frame stored
//   pkt_rx_val       read word valid (one cycle after an honoured ren)
//   pkt_rx_data      read word
//   pkt_rx_sop/eop   read word is first / last of frame
//   pkt_rx_mod       valid bytes on eop word
//   pkt_rx_err       frame error, meaningful only with pkt_rx_eop
//
// Handshake: the consumer asserts pkt_rx_ren. A word is popped on a rising
// edge only if ren=1 and a complete frame is stored before that edge. The
// popped word then appears with pkt_rx_val=1 during the following cycle. A
// ren that is not honoured produces val=0. Nothing is lost, because the
// consumer only ever reads words that are stored.
// The write side has no ready signal. Upstream must watch wr_full. Words
// written while wr_full is high are discarded and counted in drop_cnt.

module xgemac_rx_pkt_source #(
  parameter int DATA_WIDTH = 64,
  parameter int MOD_WIDTH  = 3,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_val,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_sop,
  input  logic                  wr_eop,
  input  logic [MOD_WIDTH-1:0]  wr_mod,
  input  logic                  wr_err,
  output logic                  wr_full,
  output logic [15:0]           drop_cnt,
  input  logic                  pkt_rx_ren,
  output logic                  pkt_rx_avail,
  output logic                  pkt_rx_val,
  output logic [DATA_WIDTH-1:0] pkt_rx_data,
  output logic                  pkt_rx_sop,
  output logic                  pkt_rx_eop,
  output logic [MOD_WIDTH-1:0]  pkt_rx_mod,
  output logic                  pkt_rx_err
);

  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam int CNT_W      = ADDR_WIDTH + 1;
  // Entry layout, MSB first: {data, sop, eop, mod, err}
  localparam int ENTRY_W    = DATA_WIDTH + MOD_WIDTH + 3;
  localparam int SOP_BIT    = MOD_WIDTH + 2;
  localparam int EOP_BIT    = MOD_WIDTH + 1;

  localparam logic [CNT_W-1:0]      CNT_ONE  = 1;
  localparam logic [CNT_W-1:0]      CNT_FULL = DEPTH;
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = 1;

  logic [ENTRY_W-1:0]    mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [CNT_W-1:0]      word_cnt;
  logic [CNT_W-1:0]      word_cnt_nxt;
  logic [CNT_W-1:0]      pkt_cnt;
  logic [CNT_W-1:0]      pkt_cnt_nxt;
  logic                  wr_acc;
  logic                  pop;
  logic                  pkt_inc;
  logic                  pkt_dec;
  logic [ENTRY_W-1:0]    wr_entry;
  logic [ENTRY_W-1:0]    rd_entry;

  // wr_full is the registered view of the pre-edge word count. A pop in the
  // same cycle therefore never opens room for a write while full.
  assign wr_acc   = wr_val & ~wr_full;
  // Pops are gated on complete frames only, so partial frames stay put.
  assign pop      = pkt_rx_ren & (pkt_cnt != '0);
  assign wr_entry = {wr_data, wr_sop, wr_eop, wr_mod, wr_err};
  assign rd_entry = mem[rd_ptr];
  assign pkt_inc  = wr_acc & wr_eop;
  assign pkt_dec  = pop & rd_entry[EOP_BIT];

  always_comb begin
    word_cnt_nxt = word_cnt;
    if (wr_acc && !pop)
      word_cnt_nxt = word_cnt + CNT_ONE;
    else if (!wr_acc && pop)
      word_cnt_nxt = word_cnt - CNT_ONE;
  end

  always_comb begin
    pkt_cnt_nxt = pkt_cnt;
    if (pkt_inc && !pkt_dec)
      pkt_cnt_nxt = pkt_cnt + CNT_ONE;
    else if (!pkt_inc && pkt_dec)
      pkt_cnt_nxt = pkt_cnt - CNT_ONE;
  end

  // Storage is not reset; pointers and counts define what is valid.
  always_ff @(posedge clk) begin
    if (wr_acc)
      mem[wr_ptr] <= wr_entry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      word_cnt     <= '0;
      pkt_cnt      <= '0;
      wr_full      <= 1'b0;
      drop_cnt     <= '0;
      pkt_rx_avail <= 1'b0;
      pkt_rx_val   <= 1'b0;
      pkt_rx_data  <= '0;
      pkt_rx_sop   <= 1'b0;
      pkt_rx_eop   <= 1'b0;
      pkt_rx_mod   <= '0;
      pkt_rx_err   <= 1'b0;
    end else begin
      word_cnt     <= word_cnt_nxt;
      pkt_cnt      <= pkt_cnt_nxt;
      wr_full      <= (word_cnt_nxt == CNT_FULL);
      pkt_rx_avail <= (pkt_cnt_nxt != '0);

      if (wr_acc)
        wr_ptr <= wr_ptr + PTR_ONE;

      if (wr_val && wr_full && (drop_cnt != 16'hFFFF))
        drop_cnt <= drop_cnt + 16'd1;

      if (pop) begin
        rd_ptr      <= rd_ptr + PTR_ONE;
        pkt_rx_val  <= 1'b1;
        pkt_rx_data <= rd_entry[ENTRY_W-1 -: DATA_WIDTH];
        pkt_rx_sop  <= rd_entry[SOP_BIT];
        pkt_rx_eop  <= rd_entry[EOP_BIT];
        pkt_rx_mod  <= rd_entry[MOD_WIDTH:1];
        pkt_rx_err  <= rd_entry[0];
      end else begin
        // data and mod hold their last value; the flags clear.
        pkt_rx_val  <= 1'b0;
        pkt_rx_sop  <= 1'b0;
        pkt_rx_eop  <= 1'b0;
        pkt_rx_err  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_xgemac_rx_pkt_source.sv
// tb_xgemac_rx_pkt_source
//
// Directed bench for xgemac_rx_pkt_source at default parameters. Inputs are
// driven 1 ns after each rising edge, and outputs are sampled at that point.

module tb_xgemac_rx_pkt_source;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_val;
  logic [63:0] wr_data;
  logic        wr_sop;
  logic        wr_eop;
  logic [2:0]  wr_mod;
  logic        wr_err;
  logic        wr_full;
  logic [15:0] drop_cnt;
  logic        pkt_rx_ren;
  logic        pkt_rx_avail;
  logic        pkt_rx_val;
  logic [63:0] pkt_rx_data;
  logic        pkt_rx_sop;
  logic        pkt_rx_eop;
  logic [2:0]  pkt_rx_mod;
  logic        pkt_rx_err;

  int vec_cnt = 0;
  int err_cnt = 0;

  xgemac_rx_pkt_source dut (
    .clk          (clk),
    .rst          (rst),
    .wr_val       (wr_val),
    .wr_data      (wr_data),
    .wr_sop       (wr_sop),
    .wr_eop       (wr_eop),
    .wr_mod       (wr_mod),
    .wr_err       (wr_err),
    .wr_full      (wr_full),
    .drop_cnt     (drop_cnt),
    .pkt_rx_ren   (pkt_rx_ren),
    .pkt_rx_avail (pkt_rx_avail),
    .pkt_rx_val   (pkt_rx_val),
    .pkt_rx_data  (pkt_rx_data),
    .pkt_rx_sop   (pkt_rx_sop),
    .pkt_rx_eop   (pkt_rx_eop),
    .pkt_rx_mod   (pkt_rx_mod),
    .pkt_rx_err   (pkt_rx_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  // checking
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input logic v, input logic [63:0] d, input logic s, input logic e,
                        input logic [2:0] m, input logic er);
    wr_val  = v;
    wr_data = d;
    wr_sop  = s;
    wr_eop  = e;
    wr_mod  = m;
    wr_err  = er;
  endtask

  task automatic exp_rd(input string tag, input logic [63:0] d, input logic s, input logic e,
                        input logic [2:0] m, input logic er);
    check({tag, ".val"},  pkt_rx_val,  1);
    check({tag, ".data"}, pkt_rx_data, d);
    check({tag, ".sop"},  pkt_rx_sop,  s);
    check({tag, ".eop"},  pkt_rx_eop,  e);
    check({tag, ".mod"},  pkt_rx_mod,  m);
    check({tag, ".err"},  pkt_rx_err,  er);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".avail"}, pkt_rx_avail, 0);
    check({tag, ".val"},   pkt_rx_val,   0);
    check({tag, ".data"},  pkt_rx_data,  0);
    check({tag, ".sop"},   pkt_rx_sop,   0);
    check({tag, ".eop"},   pkt_rx_eop,   0);
    check({tag, ".mod"},   pkt_rx_mod,   0);
    check({tag, ".err"},   pkt_rx_err,   0);
    check({tag, ".full"},  wr_full,      0);
    check({tag, ".drop"},  drop_cnt,     0);
  endtask

  localparam logic [63:0] D0 = 64'h1111_0000_0000_00D0;
  localparam logic [63:0] D1 = 64'h1111_0000_0000_00D1;
  localparam logic [63:0] D2 = 64'h1111_0000_0000_00D2;
  localparam logic [63:0] P0 = 64'h2222_0000_0000_00A0;
  localparam logic [63:0] P1 = 64'h2222_0000_0000_00A1;
  localparam logic [63:0] P2 = 64'h2222_0000_0000_00A2;
  localparam logic [63:0] B0 = 64'h3333_0000_0000_00B0;
  localparam logic [63:0] B1 = 64'h3333_0000_0000_00B1;
  localparam logic [63:0] B2 = 64'h3333_0000_0000_00B2;
  localparam logic [63:0] OB = 64'h4444_0000_0000_0000;
  localparam logic [63:0] WB = 64'h5555_0000_0000_0000;
  localparam logic [63:0] C0 = 64'h6666_0000_0000_00C0;
  localparam logic [63:0] E0 = 64'h7777_0000_0000_00E0;

  initial begin
    rst        = 1'b1;
    pkt_rx_ren = 1'b0;
    set_wr(0, 0, 0, 0, 0, 0);
    tick();
    tick();
    check_all_zero("rst_hold");
    rst = 1'b0;
    tick();
    check("post_rst.avail", pkt_rx_avail, 0);
    check("post_rst.full",  wr_full,      0);

    // 3-word frame, eop mod=5
    set_wr(1, D0, 1, 0, 0, 0); tick(); check("f3.avail_w0", pkt_rx_avail, 0);
    set_wr(1, D1, 0, 0, 0, 0); tick(); check("f3.avail_w1", pkt_rx_avail, 0);
    set_wr(1, D2, 0, 1, 5, 0); tick(); check("f3.avail_w2", pkt_rx_avail, 1);
    set_wr(0, 0, 0, 0, 0, 0);
    pkt_rx_ren = 1'b1;
    tick(); exp_rd("f3.r0", D0, 1, 0, 0, 0); check("f3.avail_r0", pkt_rx_avail, 1);
    tick(); exp_rd("f3.r1", D1, 0, 0, 0, 0);
    tick(); exp_rd("f3.r2", D2, 0, 1, 5, 0); check("f3.avail_r2", pkt_rx_avail, 0);
    tick();
    check("f3.val_after", pkt_rx_val,  0);
    check("f3.data_hold", pkt_rx_data, D2);
    check("f3.mod_hold",  pkt_rx_mod,  5);
    check("f3.eop_clr",   pkt_rx_eop,  0);
    pkt_rx_ren = 1'b0;

    // partial frame is not readable until its eop arrives
    set_wr(1, P0, 1, 0, 0, 0); tick();
    set_wr(1, P1, 0, 0, 0, 0); tick();
    set_wr(0, 0, 0, 0, 0, 0);
    pkt_rx_ren = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("part.val",   pkt_rx_val,   0);
      check("part.avail", pkt_rx_avail, 0);
    end
    pkt_rx_ren = 1'b0;
    set_wr(1, P2, 0, 1, 3, 0); tick(); check("part.avail_eop", pkt_rx_avail, 1);
    set_wr(0, 0, 0, 0, 0, 0);
    pkt_rx_ren = 1'b1;
    tick(); exp_rd("part.r0", P0, 1, 0, 0, 0);
    tick(); exp_rd("part.r1", P1, 0, 0, 0, 0);
    tick(); exp_rd("part.r2", P2, 0, 1, 3, 0); check("part.avail_end", pkt_rx_avail, 0);
    pkt_rx_ren = 1'b0;
    tick();

    // back-to-back: 1-word frame with err, then 2-word frame
    set_wr(1, B0, 1, 1, 0, 1); tick();
    set_wr(1, B1, 1, 0, 0, 0); tick();
    set_wr(1, B2, 0, 1, 7, 0); tick();
    set_wr(0, 0, 0, 0, 0, 0);
    check("b2b.avail", pkt_rx_avail, 1);
    pkt_rx_ren = 1'b1;
    tick(); exp_rd("b2b.r0", B0, 1, 1, 0, 1); check("b2b.avail_r0", pkt_rx_avail, 1);
    tick(); exp_rd("b2b.r1", B1, 1, 0, 0, 0);
    tick(); exp_rd("b2b.r2", B2, 0, 1, 7, 0); check("b2b.avail_r2", pkt_rx_avail, 0);
    pkt_rx_ren = 1'b0;

    // overflow: 18 words, no eop
    for (int i = 0; i < 18; i++) begin
      set_wr(1, OB + 64'(i), (i == 0), 0, 0, 0);
      tick();
      if (i == 14) check("ovf.full_15", wr_full, 0);
      if (i == 15) check("ovf.full_16", wr_full, 1);
    end
    set_wr(0, 0, 0, 0, 0, 0);
    check("ovf.drop", drop_cnt, 2);
    check("ovf.full", wr_full,  1);
    pkt_rx_ren = 1'b1;
    tick();
    check("ovf.val",   pkt_rx_val,   0);
    check("ovf.avail", pkt_rx_avail, 0);
    check("ovf.full_hold", wr_full, 1);
    pkt_rx_ren = 1'b0;

    // asynchronous reset mid-cycle clears everything at once
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    tick();
    rst = 1'b0;
    tick();
    check("rel.avail", pkt_rx_avail, 0);
    check("rel.full",  wr_full,      0);
    check("rel.drop",  drop_cnt,     0);

    // wrap-around with simultaneous eop write and eop pop
    for (int i = 0; i < 15; i++) begin
      set_wr(1, WB + 64'(i), (i == 0), (i == 14), (i == 14) ? 3'd2 : 3'd0, 0);
      tick();
    end
    set_wr(0, 0, 0, 0, 0, 0);
    check("wrap.avail", pkt_rx_avail, 1);
    pkt_rx_ren = 1'b1;
    for (int i = 0; i < 14; i++) begin
      tick();
      check("wrap.val",  pkt_rx_val,  1);
      check("wrap.data", pkt_rx_data, WB + 64'(i));
    end
    set_wr(1, C0, 1, 1, 4, 0);
    tick(); exp_rd("wrap.w14", WB + 64'd14, 0, 1, 2, 0); check("wrap.avail_s1", pkt_rx_avail, 1);
    set_wr(1, E0, 1, 1, 6, 1);
    tick(); exp_rd("wrap.c0", C0, 1, 1, 4, 0); check("wrap.avail_s2", pkt_rx_avail, 1);
    set_wr(0, 0, 0, 0, 0, 0);
    tick(); exp_rd("wrap.e0", E0, 1, 1, 6, 1); check("wrap.avail_end", pkt_rx_avail, 0);
    tick();
    check("wrap.val_end", pkt_rx_val, 0);
    check("wrap.full",    wr_full,    0);
    pkt_rx_ren = 1'b0;

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/xgemac_rx_pkt_source.md
Name: xgemac_rx_pkt_source

Overview:
- MAC-side source of the packet receive interface: buffers received frame words and presents them on pkt_rx_* to a consumer that drives pkt_rx_ren.
- pkt_rx_avail goes high only while at least one complete frame (eop written) is stored, so a consumer never reads a partial frame.
- Sits between the MAC RX datapath (write side) and the RX agent/consumer (read side).

Parameters:
- DATA_WIDTH, 64, width of pkt_rx_data and wr_data.
- MOD_WIDTH, 3, width of the mod field; byte count valid in the eop word, 0 means all 8 bytes.
- DEPTH, 16, word capacity of the buffer; must be a power of 2, at least 4.
- ADDR_WIDTH, $clog2(DEPTH), pointer width; derived, never overridden.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- wr_val  in  1  write-side word valid.
- wr_data  in  DATA_WIDTH  write word.
- wr_sop  in  1  first word of frame.
- wr_eop  in  1  last word of frame.
- wr_mod  in  MOD_WIDTH  valid bytes on eop word.
- wr_err  in  1  frame error flag, carried on eop word.
- wr_full  out  1  buffer holds DEPTH words.
- drop_cnt  out  16  count of writes dropped because full; saturates at 16'hFFFF.
- pkt_rx_ren  in  1  read enable from consumer.
- pkt_rx_avail  out  1  at least one complete frame stored.
- pkt_rx_val  out  1  read word valid.
- pkt_rx_data  out  DATA_WIDTH  read word.
- pkt_rx_sop  out  1  read word is first of frame.
- pkt_rx_eop  out  1  read word is last of frame.
- pkt_rx_mod  out  MOD_WIDTH  valid bytes on eop word.
- pkt_rx_err  out  1  frame error, meaningful only with pkt_rx_eop.

Behaviour:
- Reset: one clock (clk); reset (rst) is asynchronous and active-high. While rst is high, every output is 0, pointers are 0, word count is 0 and pkt_cnt is 0. Reset mid-frame discards all stored data, including partial frames.
- Storage: circular buffer of DEPTH entries. Each entry is {data, sop, eop, mod, err}, 70 bits at default widths. wr_ptr and rd_ptr wrap modulo DEPTH. word_cnt ranges 0..DEPTH.
- Write: on a posedge with wr_val=1 and wr_full=0, the entry is stored at wr_ptr and wr_ptr increments.
  - If wr_val=1 and wr_full=1, the word is discarded and drop_cnt increments (saturating).
  - wr_full is evaluated on the pre-edge word_cnt, so a simultaneous pop does not admit a write when full.
- pkt_cnt: counts complete frames stored.
  - +1 on an accepted write with wr_eop=1.
  - -1 on a pop of an entry with eop=1.
  - If both occur in the same cycle, pkt_cnt is unchanged.
  - pkt_rx_avail = (pkt_cnt != 0), registered, so it reflects the post-edge count.
- Read: a pop occurs on a posedge with pkt_rx_ren=1 and pkt_cnt != 0 (pre-edge). A pop loads the entry at rd_ptr into the output registers, increments rd_ptr, and sets pkt_rx_val=1 for the following cycle. Read latency is 1 cycle from ren sample to val.
- No pop (ren=0, or pkt_cnt=0): pkt_rx_val, pkt_rx_sop, pkt_rx_eop and pkt_rx_err go to 0. pkt_rx_data and pkt_rx_mod hold their last value.
- ren held high past the last eop with no further complete frame: no pop, and val drops to 0. Words of a partial frame are never popped.
- word_cnt: +1 on accepted write, -1 on pop, unchanged if both occur.
  - wr_full = (word_cnt == DEPTH), registered post-edge.
- Frame integrity on write side: wr_sop/wr_eop are stored as given, and the block does not repair protocol errors. A single-word frame (sop=1, eop=1) is legal.
- Frame larger than DEPTH: it can never complete. The upstream side must honor wr_full; dropped words are reported via drop_cnt only.
- wr_mod and wr_err are stored on all words but are only meaningful on eop words.

Test Plan:
- Reset check: assert rst asynchronously mid-cycle -> all outputs immediately 0; after release, pkt_rx_avail=0 and wr_full=0.
- Write a 3-word frame D0..D2 with eop mod=5, err=0 -> avail rises the cycle after the eop write. Hold ren=1 for 3 cycles -> val=1 for 3 cycles, data D0,D1,D2, sop on D0, eop+mod=5 on D2. Avail falls after the D2 pop.
- Partial frame: write 2 words without eop, then hold ren=1 for 4 cycles -> val stays 0 and avail stays 0. Write eop word -> avail=1, and subsequent reads return all 3 words in order.
- Back-to-back frames: a 1-word frame (sop=eop=1, err=1) followed by a 2-word frame, with ren held continuously -> 3 consecutive val cycles, err=1 on first eop, avail=0 after the final pop.
- Overflow with DEPTH=16: write 18 words with no eop -> wr_full=1 after the 16th, drop_cnt=2, and only 16 entries stored.
- Simultaneous eop write and eop pop with pkt_cnt=1 -> pkt_cnt stays 1, avail stays high, and wrap-around across rd_ptr/wr_ptr=15->0 keeps data order.
